// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and the GPR bank write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32
);

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ*5-1:0]    req_rd_i;
  logic [NREQ*XLEN-1:0] req_data_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [4:0]           rd_o;
  logic [XLEN-1:0]      datord_o;
  logic                 wren_o;

  // Arbiter side: takes requests, drives grants and the GPR write port
  modport slave (
    input  req_valid_i,
    input  req_rd_i,
    input  req_data_i,
    output req_ready_o,
    output rd_o,
    output datord_o,
    output wren_o
  );

  // Requester / bank side
  modport master (
    output req_valid_i,
    output req_rd_i,
    output req_data_i,
    input  req_ready_o,
    input  rd_o,
    input  datord_o,
    input  wren_o
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the GPR write port plus a busy scoreboard
// used by decode for RAW/WAW hazard detection.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  regfile_wb_arbiter_if.slave bus,
  input  logic                issue_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  output logic                hazard1_o,
  output logic                hazard2_o,
  output logic                hazard_rd_o,
  output logic [31:0]         busy_o
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr_nxt;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [RW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wren_q;
  logic [RW-1:0]   rd_q;
  logic [XLEN-1:0] data_q;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Round-robin search: first valid requester starting at ptr_q, wrapping to 0
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_any && bus.req_valid_i[PW'((32'(ptr_q) + i) % NREQ)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'((32'(ptr_q) + i) % NREQ);
      end
    end
  end

  // One-hot grant and mux of the winner's destination and data
  always_comb begin
    gnt      = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_any && (gnt_idx == PW'(k))) begin
        gnt[k]   = 1'b1;
        sel_rd   = bus.req_rd_i[RW*k +: RW];
        sel_data = bus.req_data_i[XLEN*k +: XLEN];
      end
    end
    ptr_nxt = PW'((32'(gnt_idx) + 1) % NREQ);
  end

  // Output stage: register the winner; x0 writes are accepted but never drive wren
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      wren_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      if (gnt_any) begin
        ptr_q <= ptr_nxt;
      end
      if (gnt_any && (sel_rd != '0)) begin
        wren_q <= 1'b1;
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end else begin
        wren_q <= 1'b0;
      end
    end
  end

  // Scoreboard next state: clear on commit, set on issue (set wins), x0 never busy
  always_comb begin
    busy_d = busy_q;
    if (wren_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.req_ready_o = gnt;
  assign bus.wren_o      = wren_q;
  assign bus.rd_o        = rd_q;
  assign bus.datord_o    = data_q;

  assign hazard1_o   = busy_q[rs1_i];
  assign hazard2_o   = busy_q[rs2_i];
  assign hazard_rd_o = busy_q[issue_rd_i];
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic        clk_i;
  logic        rst_ni;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic        hazard1_o;
  logic        hazard2_o;
  logic        hazard_rd_o;
  logic [31:0] busy_o;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .hazard1_o   (hazard1_o),
    .hazard2_o   (hazard2_o),
    .hazard_rd_o (hazard_rd_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_wren;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    r = 5'($urandom_range(31, 0));
    for (int t = 0; t < 4; t++) begin
      if (m_busy[r]) return r;
      r = 5'($urandom_range(31, 0));
    end
    return r;
  endfunction

  task automatic clear_inputs();
    bus.req_valid_i = '0;
    bus.req_rd_i    = '0;
    bus.req_data_i  = '0;
    issue_i         = 1'b0;
    issue_rd_i      = '0;
    rs1_i           = '0;
    rs2_i           = '0;
  endtask

  task automatic set_req(input int k, input logic [4:0] rd, input logic [31:0] data);
    bus.req_valid_i[k]        = 1'b1;
    bus.req_rd_i[5*k +: 5]    = rd;
    bus.req_data_i[32*k +: 32] = data;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_wren = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("rst_wren", bus.wren_o, 0);
    chk("rst_rd", bus.rd_o, 0);
    chk("rst_data", bus.datord_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  // One clock of traffic: inputs are set by the caller at a negedge
  task automatic cycle(output int g);
    logic [NREQ-1:0] e;
    logic [4:0]      rdk;
    logic [31:0]     dk;
    logic            iss;
    logic [4:0]      ird;
    logic [31:0]     nb;
    #1;
    g = exp_grant(bus.req_valid_i);
    e = '0;
    rdk = '0;
    dk  = '0;
    if (g >= 0) begin
      e[g] = 1'b1;
      rdk  = bus.req_rd_i[5*g +: 5];
      dk   = bus.req_data_i[32*g +: 32];
    end
    chk("ready", bus.req_ready_o, e);
    chk("hazard1", hazard1_o, m_busy[rs1_i]);
    chk("hazard2", hazard2_o, m_busy[rs2_i]);
    chk("hazard_rd", hazard_rd_o, m_busy[issue_rd_i]);
    iss = issue_i;
    ird = issue_rd_i;
    @(posedge clk_i);
    nb = m_busy;
    if (m_wren) nb[m_rd] = 1'b0;
    if (iss && ird != 0) nb[ird] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    m_wren = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      if (rdk != 0) begin
        m_wren = 1'b1;
        m_rd   = rdk;
        m_data = dk;
      end
    end
    @(negedge clk_i);
    chk("wren", bus.wren_o, m_wren);
    chk("busy", busy_o, m_busy);
    if (m_wren) begin
      chk("rd", bus.rd_o, m_rd);
      chk("data", bus.datord_o, m_data);
    end
  endtask

  initial begin
    int          g;
    int          waited;
    logic [31:0] busy_snap;
    logic        toggle;

    rst_ni = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    do_reset();

    // Single write with a RAW hazard that drops at the commit edge
    issue_i = 1'b1; issue_rd_i = 5'd5;
    cycle(g);
    clear_inputs();
    rs1_i = 5'd5;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", bus.req_ready_o, 3'b001);
    chk("single_haz_n", hazard1_o, 1);
    cycle(g);
    bus.req_valid_i = '0;
    chk("single_wren", bus.wren_o, 1);
    chk("single_rd", bus.rd_o, 5);
    chk("single_data", bus.datord_o, 32'hDEADBEEF);
    chk("single_haz_n1", hazard1_o, 1);
    cycle(g);
    chk("single_haz_clr", hazard1_o, 0);
    chk("single_wren_idle", bus.wren_o, 0);
    chk("single_rd_hold", bus.rd_o, 5);

    // Round-robin with all requesters continuously valid
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < NREQ; k++) set_req(k, 5'(10 + k), 32'($urandom));
      cycle(g);
      chk("rr_grant", g, c % NREQ);
      chk("rr_wren", bus.wren_o, 1);
    end
    clear_inputs();
    cycle(g);

    // x0 write: accepted, no write, scoreboard untouched
    busy_snap = busy_o;
    set_req(1, 5'd0, 32'h12345678);
    #1;
    chk("x0_ready", bus.req_ready_o, 3'b010);
    cycle(g);
    clear_inputs();
    chk("x0_wren", bus.wren_o, 0);
    chk("x0_busy", busy_o, busy_snap);

    // Same-edge commit and re-issue of r7: set wins
    issue_i = 1'b1; issue_rd_i = 5'd7;
    cycle(g);
    clear_inputs();
    set_req(0, 5'd7, 32'hA5A5A5A5);
    cycle(g);
    clear_inputs();
    chk("coll_wren", bus.wren_o, 1);
    issue_i = 1'b1; issue_rd_i = 5'd7;
    cycle(g);
    clear_inputs();
    chk("coll_busy7", busy_o[7], 1);

    // Starvation: req2 held, req0 toggling
    waited = 0;
    toggle = 1'b1;
    g = -1;
    set_req(2, 5'd3, 32'hCAFE0002);
    while (g != 2 && waited <= NREQ) begin
      if (toggle) set_req(0, 5'd4, 32'($urandom));
      else bus.req_valid_i[0] = 1'b0;
      cycle(g);
      waited++;
      if (g == 0) bus.req_valid_i[0] = 1'b0;
      toggle = ~toggle;
    end
    chk("starve_bound", (waited <= NREQ), 1);
    clear_inputs();
    cycle(g);

    // Async reset in the middle of a write
    do_reset();
    issue_i = 1'b1; issue_rd_i = 5'd9;
    set_req(0, 5'd9, 32'h0BADF00D);
    cycle(g);
    clear_inputs();
    chk("midrst_pre_wren", bus.wren_o, 1);
    chk("midrst_pre_busy9", busy_o[9], 1);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("midrst_wren", bus.wren_o, 0);
    chk("midrst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < NREQ; k++) set_req(k, 5'(20 + k), 32'($urandom));
    #1;
    chk("midrst_ptr0", bus.req_ready_o, 3'b001);
    cycle(g);
    clear_inputs();
    cycle(g);

    // Random traffic with requesters holding requests until accepted
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!bus.req_valid_i[k] && ($urandom_range(1, 0) == 1)) begin
          set_req(k, pick_rd(), 32'($urandom));
        end
      end
      issue_i    = 1'b0;
      issue_rd_i = 5'($urandom_range(31, 0));
      if ($urandom_range(1, 0) == 1 && !m_busy[issue_rd_i]) issue_i = 1'b1;
      rs1_i = 5'($urandom_range(31, 0));
      rs2_i = 5'($urandom_range(31, 0));
      cycle(g);
      if (g >= 0) bus.req_valid_i[g] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
